// File: rtl/clkctl_pkg.sv
// Shared definitions for the clock step controller: command encodings, FSM states
// and the default step-count width.
package clkctl_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_RUN  = 2'b01,
        OP_HALT = 2'b10,
        OP_STEP = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_STEPPING = 2'b10
    } state_t;

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter for the number of gated edges still owed; the decrement
// saturates at zero so the count can never wrap.
module step_counter
    import clkctl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (dec && (value_q != '0)) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/clock_step_ctrl.sv
// Run/halt/single-step sequencer driving the edgegate enable for the CPU core clock.
// Optional `GATED_CYCLE_COUNT_EN adds a 32-bit count of delivered gated edges.
module clock_step_ctrl
    import clkctl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter bit RUN_ON_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             halt_req,
    output logic             gate_en,
    output logic             running,
    output logic             step_done,
    output logic [CNT_W-1:0] remaining
`ifdef GATED_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_count
`endif
);

    localparam state_t RST_STATE = RUN_ON_RST ? ST_RUNNING : ST_HALTED;

    state_t           state_q, state_d;
    cmd_op_t          op;
    logic             done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt_val;
    logic             stepping;

    assign op        = cmd_op_t'(cmd_op);
    assign stepping  = (state_q == ST_STEPPING);
    assign cmd_ready = !halt_req;

    // Priority: core halt request, then an accepted non-NOP command, then step progress.
    // NOTE: every always_comb output gets a default before any branch; a missed path
    // would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (halt_req) begin
            state_d = ST_HALTED;
            if (stepping) begin
                done_d   = 1'b1;
                cnt_load = 1'b1;
            end
        end else if (cmd_valid && (op != OP_NOP)) begin
            cnt_load = 1'b1;
            case (op)
                OP_RUN:  state_d = ST_RUNNING;
                OP_HALT: begin
                    state_d = ST_HALTED;
                    done_d  = stepping;
                end
                OP_STEP: begin
                    if (cmd_count == '0) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_STEPPING;
                        cnt_load_val = cmd_count;
                    end
                end
                default: ;
            endcase
        end else if (stepping) begin
            cnt_dec = 1'b1;
            // The cycle showing remaining==1 delivers the last owed edge.
            if (cnt_zero || (cnt_val == CNT_W'(1))) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            gate_en   <= RUN_ON_RST;
            running   <= RUN_ON_RST;
            step_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_en   <= (state_d != ST_HALTED);
            running   <= (state_d != ST_HALTED);
            step_done <= done_d;
        end
    end

    step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cnt_val),
        .zero     (cnt_zero)
    );

    assign remaining = cnt_val;

`ifdef GATED_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (gate_en) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
